// File: rtl/mem_access_stage.sv
// MEM stage: zero-latency pass-through for ALU ops; loads/stores run a req/ack memory transaction (>=3 cycles).
// Backpressure: o_stall freezes upstream while a memory op is in flight; optional abort under MEM_STAGE_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_WE,
  input  logic [DATA_W-1:0] i_WB_Dir,
  output logic              o_stall,
  output logic              o_WE_MEM_WB,
  output logic [DATA_W-1:0] o_WB_Data,
  output logic [DATA_W-1:0] o_WB_Dir,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [DATA_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_dir;
  logic              r_we;
  logic              r_is_wr;
  logic              w_start;
  logic              w_ack;
  logic              w_abort;
  logic              w_aborted;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign w_start = (r_state == IDLE) && i_valid && (i_mem_rd || i_mem_wr);
  assign w_ack   = (r_state == BUSY) && i_dmem_ack;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tmo_cnt;
  logic       r_timeout;

  // Abort on the edge that would bring the count to TIMEOUT_CYCLES; an ack on that edge wins.
  assign w_abort = (r_state == BUSY) && !i_dmem_ack && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start)
        r_tmo_cnt <= 8'd0;
      else if (r_state == BUSY && !i_dmem_ack)
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      r_timeout <= w_abort;
    end
  end

  assign w_aborted = r_timeout;
  assign o_timeout = r_timeout;
`else
  assign w_abort   = 1'b0;
  assign w_aborted = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_stall      = 1'b0;
    o_WE_MEM_WB  = 1'b0;
    o_WB_Data    = i_alu_result;
    o_WB_Dir     = i_WB_Dir;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          o_stall      = 1'b1;
          w_next_state = BUSY;
        end else if (i_valid) begin
          o_WE_MEM_WB = i_WE;
        end
      end
      BUSY: begin
        o_stall = 1'b1;
        if (w_ack || w_abort)
          w_next_state = DONE;
      end
      DONE: begin
        o_WB_Dir     = r_dir;
        w_next_state = IDLE;
        if (r_is_wr) begin
          o_WB_Data = '0;
        end else begin
          o_WE_MEM_WB = r_we && !w_aborted;
          o_WB_Data   = r_rdata;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Store wins when rd and wr are both set: the wr flag alone selects the transaction type.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_rdata      <= '0;
      r_dir        <= '0;
      r_we         <= 1'b0;
      r_is_wr      <= 1'b0;
    end else if (w_start) begin
      r_dmem_req   <= 1'b1;
      r_dmem_we    <= i_mem_wr;
      r_dmem_addr  <= i_alu_result;
      r_dmem_wdata <= i_store_data;
      r_is_wr      <= i_mem_wr;
      r_we         <= i_WE;
      r_dir        <= i_WB_Dir;
    end else if (w_ack) begin
      r_rdata    <= i_dmem_rdata;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
    end else if (w_abort) begin
      r_rdata    <= '0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
    end
  end

  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: scenario tasks with a transaction-level reference model.
// Build with MEM_STAGE_TIMEOUT_EN to also exercise the abort path (TIMEOUT_CYCLES=3).
module tb_mem_access_stage;
  localparam int DW  = 32;
  localparam int TMO = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid, i_mem_rd, i_mem_wr, i_WE, i_dmem_ack;
  logic [DW-1:0] i_alu_result, i_store_data, i_WB_Dir, i_dmem_rdata;
  logic          o_stall, o_WE_MEM_WB, o_dmem_req, o_dmem_we, o_timeout;
  logic [DW-1:0] o_WB_Data, o_WB_Dir, o_dmem_addr, o_dmem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_WE(i_WE), .i_WB_Dir(i_WB_Dir),
    .o_stall(o_stall), .o_WE_MEM_WB(o_WE_MEM_WB), .o_WB_Data(o_WB_Data), .o_WB_Dir(o_WB_Dir),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_timeout(o_timeout)
  );

  task automatic drive_bubble();
    i_valid      = 1'b0;
    i_mem_rd     = 1'b0;
    i_mem_wr     = 1'b0;
    i_alu_result = $urandom;
    i_store_data = $urandom;
    i_WE         = 1'($urandom_range(0, 1));
    i_WB_Dir     = $urandom_range(0, 31);
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one memory instruction from its IDLE cycle through DONE; caller is just past a rising edge.
  // ack_at: BUSY cycle (1-based) on which ack is driven, 0 = never.
  task automatic run_mem_txn(input bit rd, input bit wr, input logic [DW-1:0] addr,
                             input logic [DW-1:0] wdata, input bit we, input logic [DW-1:0] dir,
                             input int ack_at, input logic [DW-1:0] rdata, input string tag);
    bit            store;
    bit            aborted;
    int            busy_n;
    int            stall_cnt;
    logic [DW-1:0] exp_data;
    store = wr;
`ifdef MEM_STAGE_TIMEOUT_EN
    aborted = (ack_at == 0) || (ack_at > TMO);
    busy_n  = aborted ? TMO : ack_at;
`else
    aborted = 1'b0;
    busy_n  = ack_at;
`endif
    stall_cnt = 0;
    i_valid = 1'b1; i_mem_rd = rd; i_mem_wr = wr; i_alu_result = addr; i_store_data = wdata;
    i_WE = we; i_WB_Dir = dir;
    i_dmem_ack = 1'($urandom_range(0, 1));
    i_dmem_rdata = $urandom;
    @(negedge clk);
    checks++;
    if ({o_stall, o_WE_MEM_WB, o_dmem_req, o_timeout} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_idle: stall/we/req/tmo got %b expected 1000", tag,
               {o_stall, o_WE_MEM_WB, o_dmem_req, o_timeout});
    end
    stall_cnt += int'(o_stall);
    next_cycle();
    for (int k = 1; k <= busy_n; k++) begin
      i_dmem_ack   = (!aborted && k == ack_at);
      i_dmem_rdata = (k == ack_at) ? rdata : DW'($urandom);
      @(negedge clk);
      checks++;
      if ({o_stall, o_WE_MEM_WB, o_dmem_req, o_dmem_we, o_timeout, o_dmem_addr, o_dmem_wdata}
          !== {1'b1, 1'b0, 1'b1, store, 1'b0, addr, wdata}) begin
        errors++;
        $display("FAIL %s_busy%0d: stall/we/req/dwe/tmo=%b addr=%h wdata=%h expected %b addr=%h wdata=%h",
                 tag, k, {o_stall, o_WE_MEM_WB, o_dmem_req, o_dmem_we, o_timeout}, o_dmem_addr,
                 o_dmem_wdata, {1'b1, 1'b0, 1'b1, store, 1'b0}, addr, wdata);
      end
      stall_cnt += int'(o_stall);
      next_cycle();
    end
    i_dmem_ack   = 1'($urandom_range(0, 1));
    i_dmem_rdata = ~rdata;
    @(negedge clk);
    checks++;
    if ({o_stall, o_WE_MEM_WB, o_dmem_req, o_dmem_we, o_timeout}
        !== {1'b0, (store || aborted) ? 1'b0 : we, 1'b0, 1'b0, aborted}) begin
      errors++;
      $display("FAIL %s_done_ctl: stall/we/req/dwe/tmo got %b expected %b", tag,
               {o_stall, o_WE_MEM_WB, o_dmem_req, o_dmem_we, o_timeout},
               {1'b0, (store || aborted) ? 1'b0 : we, 1'b0, 1'b0, aborted});
    end
    if (!aborted) begin
      exp_data = store ? '0 : rdata;
      checks++;
      if ({o_WB_Data, o_WB_Dir} !== {exp_data, dir}) begin
        errors++;
        $display("FAIL %s_done_wb: data=%h dir=%h expected data=%h dir=%h", tag, o_WB_Data,
                 o_WB_Dir, exp_data, dir);
      end
    end
    checks++;
    if (stall_cnt != busy_n + 1) begin
      errors++;
      $display("FAIL %s_stall_len: got %0d cycles expected %0d", tag, stall_cnt, busy_n + 1);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_bubble();
    @(negedge clk);
    checks++;
    if ({o_dmem_req, o_dmem_we, o_timeout, o_stall, o_WE_MEM_WB, o_dmem_addr, o_dmem_wdata,
         o_WB_Data, o_WB_Dir} !== {5'b0, 64'b0, i_alu_result, i_WB_Dir}) begin
      errors++;
      $display("FAIL reset: ctl=%b addr=%h wdata=%h wbdata=%h wbdir=%h expected ctl=00000 0 0 %h %h",
               {o_dmem_req, o_dmem_we, o_timeout, o_stall, o_WE_MEM_WB}, o_dmem_addr, o_dmem_wdata,
               o_WB_Data, o_WB_Dir, i_alu_result, i_WB_Dir);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_alu();
    for (int n = 0; n < 9; n++) begin
      i_valid = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
      i_alu_result = (n == 0) ? 32'h0000_1234 : DW'($urandom);
      i_WB_Dir     = (n == 0) ? 32'd5 : DW'($urandom_range(0, 31));
      i_WE         = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i_store_data = $urandom;
      i_dmem_ack   = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({o_stall, o_WE_MEM_WB, o_dmem_req, o_WB_Data, o_WB_Dir}
          !== {1'b0, i_WE, 1'b0, i_alu_result, i_WB_Dir}) begin
        errors++;
        $display("FAIL alu%0d: stall/we/req=%b data=%h dir=%h expected 0%b0 data=%h dir=%h", n,
                 {o_stall, o_WE_MEM_WB, o_dmem_req}, o_WB_Data, o_WB_Dir, i_WE, i_alu_result, i_WB_Dir);
      end
      next_cycle();
    end
  endtask

  task automatic test_load();
    run_mem_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'd7, 1, 32'hDEAD_BEEF, "load");
  endtask

  task automatic test_store();
    run_mem_txn(1'b0, 1'b1, 32'h80, 32'hA5A5_A5A5, 1'b1, 32'd9, 4, 32'h1111_2222, "store");
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    run_mem_txn(1'b1, 1'b0, 32'hC0, 32'h0, 1'b1, 32'd3, 0, 32'h0, "tmo_abort");
    run_mem_txn(1'b1, 1'b0, 32'hC4, 32'h0, 1'b1, 32'd4, TMO, 32'h5555_AAAA, "tmo_ack_last");
  endtask
`endif

  task automatic test_back_to_back();
    run_mem_txn(1'b1, 1'b1, 32'h100, 32'h0BAD_F00D, 1'b1, 32'd11, 2, 32'h7777_7777, "b2b_rdwr");
    run_mem_txn(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 32'd12, 1, 32'h1357_9BDF, "b2b_load");
  endtask

  task automatic test_random_mem();
    for (int n = 0; n < 12; n++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      run_mem_txn(!wr || 1'($urandom_range(0, 1)), wr, DW'($urandom), DW'($urandom),
                  1'($urandom_range(0, 1)), DW'($urandom_range(0, 31)), $urandom_range(1, 6),
                  DW'($urandom), "rand");
      if ($urandom_range(0, 1) == 1) begin
        drive_bubble();
        next_cycle();
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    run_mem_txn(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'd2, 1, 32'h2468_ACE0, "pre_rst");
    i_valid = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b0; i_alu_result = 32'h300; i_dmem_ack = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (o_dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_req: got %b expected 1", o_dmem_req);
    end
    rst_n = 1'b0;
    i_valid = 1'b0; i_mem_rd = 1'b0;
    #1;
    checks++;
    if ({o_dmem_req, o_dmem_we, o_stall, o_WE_MEM_WB, o_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: req/dwe/stall/we/tmo got %b expected 00000",
               {o_dmem_req, o_dmem_we, o_stall, o_WE_MEM_WB, o_timeout});
    end
    next_cycle();
    rst_n = 1'b1;
    i_valid = 1'b1; i_alu_result = 32'hCAFE_0001; i_WB_Dir = 32'd3; i_WE = 1'b1;
    #1;
    checks++;
    if ({o_stall, o_WE_MEM_WB, o_dmem_req, o_WB_Data} !== {3'b010, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL rst_then_alu: stall/we/req=%b data=%h expected 010 data=cafe0001",
               {o_stall, o_WE_MEM_WB, o_dmem_req}, o_WB_Data);
    end
    next_cycle();
    drive_bubble();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_bubble();
    test_reset();
    test_alu();
    test_load();
    test_store();
`ifdef MEM_STAGE_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_alu();
    test_random_mem();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the filter processor pipeline. It sits between the EX/MEM register and the MEM/WB register and drives the MEM/WB inputs (write-enable, write-back data, write-back destination) every cycle. Non-memory instructions pass through unchanged. Loads and stores run a variable-latency req/ack transaction on the data-memory port and stall upstream stages until the transaction finishes.

## Interface
- DATA_W, 32, data and address width
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (used only with the timeout macro); 8-bit counter, legal range 1..255
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  EX/MEM holds a valid instruction
- i_mem_rd / i_mem_wr  in  1 each  load / store request
- i_alu_result  in  DATA_W  memory address, or result for non-memory instructions
- i_store_data  in  DATA_W  store data
- i_WE  in  1  instruction writes the register file
- i_WB_Dir  in  DATA_W  destination register
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- o_WE_MEM_WB / o_WB_Data / o_WB_Dir  out  1 / DATA_W / DATA_W  to MEM/WB register inputs
- o_dmem_req, o_dmem_we  out  1 each  memory request, write strobe
- o_dmem_addr, o_dmem_wdata  out  DATA_W each  memory address, write data
- i_dmem_ack  in  1  memory completes the transaction; i_dmem_rdata valid in the same cycle
- i_dmem_rdata  in  DATA_W  load data
- o_timeout  out  1  one-cycle abort pulse

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata and o_timeout are 0, as are all latched fields. In IDLE with i_valid=0: o_stall=0, o_WE_MEM_WB=0, o_WB_Data=i_alu_result, o_WB_Dir=i_WB_Dir.
- IDLE, non-memory instruction (i_valid and neither rd nor wr): combinational pass-through with zero latency.
  - o_WE_MEM_WB=i_WE, o_WB_Data=i_alu_result, o_WB_Dir=i_WB_Dir, o_stall=0.
- IDLE, memory instruction: o_stall=1 and o_WE_MEM_WB=0, which inserts a bubble into MEM/WB.
  - On the next edge: latch addr, wdata, the wr flag, i_WE and i_WB_Dir; assert o_dmem_req; set o_dmem_we=i_mem_wr; go to BUSY.
  - If rd and wr are both set, the store wins.
- BUSY: o_stall=1, o_WE_MEM_WB=0. Request fields stay stable until the edge on which i_dmem_ack=1 is sampled.
  - On that edge: capture i_dmem_rdata, clear req and we, go to DONE.
- DONE: o_stall=0.
  - Load: o_WE_MEM_WB=latched i_WE, o_WB_Data=captured rdata, o_WB_Dir=latched dir.
  - Store: o_WE_MEM_WB=0, o_WB_Data=0.
  - The next edge loads MEM/WB, advances the upstream pipeline and returns to IDLE.
- i_dmem_ack in IDLE or DONE is ignored.
- rst_n low in any state forces IDLE and clears req immediately. The memory must tolerate an abandoned request.

## Timing
- Non-memory instruction: 0 added cycles.
- Memory instruction: at least 3 cycles in the stage (IDLE, BUSY with ack, DONE). That is 2 stall cycles plus N extra, where N is the number of BUSY cycles before ack.
- o_dmem_* are registered outputs. o_stall and the MEM/WB-side outputs are combinational from state and inputs.
- Back-to-back memory instructions: the second one is first seen in the IDLE cycle after DONE. No overlap.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop req, go to DONE, force o_WE_MEM_WB=0, pulse o_timeout=1 during DONE.
  - Ack on the same edge as the timeout wins; no abort.
- Not defined: BUSY waits indefinitely, o_timeout is tied 0, and no counter is built.

## Test plan
- Reset mid-BUSY (rst_n low for 1 cycle): o_dmem_req=0 immediately, state IDLE, o_stall=0 with i_valid=0.
- ALU op, i_alu_result=0x0000_1234, i_WB_Dir=5, i_WE=1 -> same cycle o_WE_MEM_WB=1, o_WB_Data=0x1234, o_WB_Dir=5, o_stall=0.
- Load addr 0x40, ack on the first BUSY cycle with rdata 0xDEADBEEF -> o_dmem_req high exactly 1 cycle, o_stall high 2 cycles, DONE drives WE=1 and data 0xDEADBEEF.
- Store addr 0x80, data 0xA5A5A5A5, ack after 4 BUSY cycles -> o_dmem_we=1 with stable addr/wdata for all 4 cycles; o_WE_MEM_WB stays 0 throughout; stall lasts 5 cycles.
- Timeout build, TIMEOUT_CYCLES=3, no ack -> req drops after 3 BUSY cycles, o_timeout pulses 1 cycle, o_WE_MEM_WB=0. Repeat with ack at cycle 3 -> normal completion, no pulse.
- Load with both rd and wr set, then back-to-back load -> first is treated as a store; the second load's req rises the cycle after IDLE re-entry.
